decode_stage: RTL

- Instruction-decode stage directly upstream of the Execute stage.
- Latches the 16-bit instruction and its address from fetch, and reads the 8x8-bit register file.
- Presents IR, valA, valB, X and Addr to Execute through a one-deep pipeline register.
- Tracks in-flight register writes with a scoreboard, stalls on hazards and accepts write-back from the downstream stage.

---
 rtl/risc_pkg.sv | 50 +++++
 rtl/decode_stage_if.sv | 32 +++
 rtl/reg_file_8x8.sv | 30 +++
 rtl/decode_stage.sv | 97 +++++++++
 4 files changed

// File: rtl/risc_pkg.sv
// Shared decode definitions: opcode values, instruction field positions and
// per-opcode register usage.
package risc_pkg;

  localparam int NREG   = 8;
  localparam int DW     = 8;
  localparam int RW     = 3;
  localparam int OP_MSB = 15;
  localparam int OP_LSB = 11;
  localparam int RA_LSB = 8;
  localparam int RB_LSB = 5;

  localparam logic [15:0] NOP_IR = 16'hF800;

  typedef enum logic [4:0] {
    OP_ADD = 5'b00000,
    OP_SUB = 5'b00001,
    OP_AND = 5'b00010,
    OP_OR  = 5'b00011,
    OP_LDI = 5'b00100,
    OP_LD  = 5'b00101,
    OP_ST  = 5'b00110,
    OP_JMP = 5'b00111,
    OP_JZ  = 5'b01000,
    OP_NOP = 5'b11111
  } opcode_e;

  // Opcodes outside the list fall to default: no register is read or written.
  function automatic logic writes_ra(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_LDI, OP_LD: writes_ra = 1'b1;
      default:                                     writes_ra = 1'b0;
    endcase
  endfunction

  function automatic logic reads_ra(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ST, OP_JZ: reads_ra = 1'b1;
      default:                                    reads_ra = 1'b0;
    endcase
  endfunction

  function automatic logic reads_rb(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ST: reads_rb = 1'b1;
      default:                             reads_rb = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch offer, Execute hand-off and write-back signals of the decode stage.
// Handshake: a transfer happens on a rising edge where valid and ready are both
// 1; ready may depend on valid, and valid never depends on ready.
interface decode_stage_if;
  import risc_pkg::*;

  logic            if_valid;
  logic [15:0]     if_IR;
  logic [15:0]     if_Addr;
  logic            if_ready;
  logic            ex_ready;
  logic            id_valid;
  logic [15:0]     IR;
  logic [DW-1:0]   valA;
  logic [DW-1:0]   valB;
  logic [DW-1:0]   X;
  logic [15:0]     Addr;
  logic            wb_en;
  logic [RW-1:0]   wb_reg;
  logic [DW-1:0]   wb_data;

  modport master (
    output if_valid, if_IR, if_Addr, ex_ready, wb_en, wb_reg, wb_data,
    input  if_ready, id_valid, IR, valA, valB, X, Addr
  );

  modport slave (
    input  if_valid, if_IR, if_Addr, ex_ready, wb_en, wb_reg, wb_data,
    output if_ready, id_valid, IR, valA, valB, X, Addr
  );

endinterface

// File: rtl/reg_file_8x8.sv
// 8x8-bit register file: two combinational read ports that see a same-cycle
// write (write-first), one synchronous write port, synchronous clear.
module reg_file_8x8
  import risc_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [RW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [RW-1:0] raddr_a,
  input  logic [RW-1:0] raddr_b,
  output logic [DW-1:0] rdata_a,
  output logic [DW-1:0] rdata_b
);

  logic [DW-1:0] mem [NREG];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = (we && (waddr == raddr_a)) ? wdata : mem[raddr_a];
  assign rdata_b = (we && (waddr == raddr_b)) ? wdata : mem[raddr_b];

endmodule

// File: rtl/decode_stage.sv
// Decode stage: reads operands for the offered instruction, tracks pending
// register writes in a one-bit-per-register scoreboard and feeds Execute.
module decode_stage
  import risc_pkg::*;
(
  input  logic            T1,
  input  logic            rst,
  decode_stage_if.slave   bus,
  output logic [NREG-1:0] busy
);

  logic [4:0]      op;
  logic [RW-1:0]   ra;
  logic [RW-1:0]   rb;
  logic [DW-1:0]   rd_a;
  logic [DW-1:0]   rd_b;
  logic [NREG-1:0] wb_mask;
  logic [NREG-1:0] pending;
  logic [NREG-1:0] busy_next;
  logic            hazard;
  logic            adv;
  logic            ready;
  logic            accept;

  logic            id_valid_q;
  logic [15:0]     ir_q;
  logic [DW-1:0]   val_a_q;
  logic [DW-1:0]   val_b_q;
  logic [DW-1:0]   x_q;
  logic [15:0]     addr_q;

  assign op = bus.if_IR[OP_MSB:OP_LSB];
  assign ra = bus.if_IR[RA_LSB +: RW];
  assign rb = bus.if_IR[RB_LSB +: RW];

  reg_file_8x8 u_rf (
    .clk     (T1),
    .rst     (rst),
    .we      (bus.wb_en),
    .waddr   (bus.wb_reg),
    .wdata   (bus.wb_data),
    .raddr_a (ra),
    .raddr_b (rb),
    .rdata_a (rd_a),
    .rdata_b (rd_b)
  );

  // A register being written back this cycle is no longer pending for the offer.
  always_comb begin
    wb_mask = '0;
    if (bus.wb_en) wb_mask[bus.wb_reg] = 1'b1;
    pending = busy & ~wb_mask;
    hazard  = (reads_ra(op) && pending[ra]) ||
              (reads_rb(op) && pending[rb]) ||
              (writes_ra(op) && pending[ra]);
    adv     = !id_valid_q || bus.ex_ready;
    ready   = adv && !(bus.if_valid && hazard);
    accept  = bus.if_valid && ready;
    busy_next = pending;
    if (accept && writes_ra(op)) busy_next[ra] = 1'b1;
  end

  always_ff @(posedge T1) begin
    if (rst) begin
      busy       <= '0;
      id_valid_q <= 1'b0;
      ir_q       <= NOP_IR;
      val_a_q    <= '0;
      val_b_q    <= '0;
      x_q        <= '0;
      addr_q     <= '0;
    end else begin
      busy <= busy_next;
      if (accept) begin
        id_valid_q <= 1'b1;
        ir_q       <= bus.if_IR;
        val_a_q    <= rd_a;
        val_b_q    <= rd_b;
        x_q        <= bus.if_IR[7:0];
        addr_q     <= bus.if_Addr;
      end else if (adv) begin
        // Bubble: Execute must never see the previous instruction twice.
        id_valid_q <= 1'b0;
        ir_q       <= NOP_IR;
      end
    end
  end

  assign bus.if_ready = ready;
  assign bus.id_valid = id_valid_q;
  assign bus.IR       = ir_q;
  assign bus.valA     = val_a_q;
  assign bus.valB     = val_b_q;
  assign bus.X        = x_q;
  assign bus.Addr     = addr_q;

endmodule
